// File: rtl/rr_arb4_idx.sv
// Four-requester round-robin arbiter producing a registered 2-bit grant index
// and valid flag, with release on done, request drop, or hold-limit expiry.
module rr_arb4_idx #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold count of a grant; only meaningful when HOLD_MAX != 0.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [7:0] hold_q,  hold_d;
    logic [1:0] idx_q,   idx_d;
    logic       vld_q,   vld_d;
    logic       to_q,    to_d;

    logic       rel_norm;
    logic       rel_expire;

    function automatic logic [1:0] first_req(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] res;
        logic [1:0] cand;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = p + 2'(i);
            if (!found && r[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign rel_norm   = done || !req[idx_q];
    assign rel_expire = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        vld_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = first_req(req, ptr_q);
                    vld_d   = 1'b1;
                    hold_d  = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                vld_d  = 1'b1;
                hold_d = hold_q + 8'd1;
                if (rel_norm || rel_expire) begin
                    // A coincident done or request drop counts as a normal release.
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    to_d    = rel_expire && !rel_norm;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            hold_q  <= 8'd0;
            idx_q   <= 2'b00;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end

    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;
    assign timeout   = to_q;

endmodule
